// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx.sv
// Unbuffered 8N1 serializer; takes a new byte only when idle or on the last stop-bit cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [UART_DATA_BITS-1:0] byte_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    output logic                      uart_tx_out,
    output logic                      busy_out
);

    localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [CNT_W-1:0]          bit_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      bit_last;

    assign bit_last  = (bit_cnt == CNT_LAST);
    // Accepting on the final stop cycle lets back-to-back frames run with no idle gap.
    assign ready_out = (state == IDLE) || ((state == STOP) && bit_last);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            uart_tx_out <= 1'b1;
            busy_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (valid_in) begin
                        shreg       <= byte_in;
                        state       <= START;
                        uart_tx_out <= 1'b0;
                        busy_out    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_last) begin
                        bit_cnt     <= '0;
                        bit_idx     <= '0;
                        state       <= DATA;
                        uart_tx_out <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state       <= STOP;
                            uart_tx_out <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + IDX_W'(1);
                            shreg       <= {1'b0, shreg[UART_DATA_BITS-1:1]};
                            uart_tx_out <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (valid_in) begin
                            shreg       <= byte_in;
                            state       <= START;
                            uart_tx_out <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    uart_tx_out <= 1'b1;
                    busy_out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Byte FIFO in front of the 8N1 serializer so receive bursts can be echoed without loss.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 12_000_000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [UART_DATA_BITS-1:0]   byte_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic                        uart_tx_out,
    output logic                        busy_out,
    output logic [$clog2(FIFO_DEPTH):0] count_out
);

    localparam int unsigned CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W          = PTR_W + 1;

    logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      tx_ready;
    logic                      tx_busy;

    assign fifo_empty = (count_out == '0);
    assign ready_out  = (count_out != CNT_W'(FIFO_DEPTH));
    assign push       = valid_in && ready_out && !rst_in;
    assign pop        = tx_ready && !fifo_empty && !rst_in;
    assign busy_out   = !fifo_empty || tx_busy;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_out <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_out <= count_out + CNT_W'(1);
                2'b01:   count_out <= count_out - CNT_W'(1);
                default: count_out <= count_out;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    uart_tx #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .byte_in     (mem[rd_ptr]),
        .valid_in    (!fifo_empty),
        .ready_out   (tx_ready),
        .uart_tx_out (uart_tx_out),
        .busy_out    (tx_busy)
    );

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timeline reference model checked every cycle plus directed checks.
module tb_uart_tx_buffered;

    localparam int C     = 8;
    localparam int FL    = 10 * C;
    localparam int DEPTH = 16;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] byte_in;
    logic       valid_in;
    logic       ready_out;
    logic       uart_tx_out;
    logic       busy_out;
    logic [4:0] count_out;

    uart_tx_buffered dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .byte_in     (byte_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .uart_tx_out (uart_tx_out),
        .busy_out    (busy_out),
        .count_out   (count_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference: queue of waiting bytes plus the position inside the frame on the wire.
    logic [7:0] q[$];
    bit         in_frame = 1'b0;
    int         pos      = 0;
    logic [7:0] cur      = 8'h00;
    bit         acc      = 1'b0;

    function automatic logic exp_line();
        if (!in_frame)       return 1'b1;
        if (pos < C)         return 1'b0;
        if (pos < 9 * C)     return cur[(pos - C) / C];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
        if (r) begin
            q.delete();
            in_frame = 1'b0;
            pos      = 0;
            acc      = 1'b0;
            return;
        end
        acc = v && (q.size() < DEPTH);
        if (in_frame) begin
            pos++;
            if (pos == FL) in_frame = 1'b0;
        end
        if (!in_frame && q.size() > 0) begin
            cur      = q.pop_front();
            in_frame = 1'b1;
            pos      = 0;
        end
        if (acc) q.push_back(b);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        rst_in   = r;
        valid_in = v;
        byte_in  = b;
        @(posedge clk_in);
        cyc++;
        model_edge(r, v, b);
        #1;
        check("line",  32'(uart_tx_out), 32'(exp_line()));
        check("count", 32'(count_out),   32'(q.size()));
        check("ready", 32'(ready_out),   32'(q.size() < DEPTH));
        check("busy",  32'(busy_out),    32'((q.size() != 0) || in_frame));
    endtask

    int  t0;
    int  fall;
    int  acc_n;
    int  ff_acc;
    int  lows;
    logic v;
    int  pct [3] = '{20, 60, 95};

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        byte_in  = 8'h00;
        #2;

        // Reset held three cycles with a coinciding valid that must not be stored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h77);
        check("rst_tx",    32'(uart_tx_out), 32'd1);
        check("rst_ready", 32'(ready_out),   32'd1);
        check("rst_busy",  32'(busy_out),    32'd0);
        check("rst_cnt",   32'(count_out),   32'd0);

        // Single byte: busy must drop exactly 81 edges after the accept.
        step(1'b0, 1'b1, 8'hA5);
        t0   = cyc;
        fall = -1;
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (fall < 0 && !busy_out) fall = cyc;
        end
        check("single_busy_fall", 32'(fall - t0), 32'd81);

        // Burst with valid held high until ready drops.
        acc_n = 0;
        t0    = -1;
        for (int i = 0; i < 64 && ready_out; i++) begin
            step(1'b0, 1'b1, 8'(acc_n));
            if (acc) begin
                acc_n++;
                if (t0 < 0) t0 = cyc;
            end
        end
        check("burst_accepted", 32'(acc_n),     32'd17);
        check("burst_count",    32'(count_out), 32'd16);

        // Offer 0xFF only while full; none may be stored.
        ff_acc = 0;
        fall   = -1;
        for (int i = 0; i < 1500; i++) begin
            if (!ready_out) step(1'b0, 1'b1, 8'hFF);
            else            step(1'b0, 1'b0, 8'h00);
            if (acc) ff_acc++;
            if (fall < 0 && !busy_out) fall = cyc;
        end
        check("overflow_stored", 32'(ff_acc),     32'd0);
        check("burst_span",      32'(fall - t0),  32'd1361);

        // Push on the last stop cycle while one byte waits: count holds, next start is immediate.
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'hC3);
        check("pp_count_before", 32'(count_out), 32'd1);
        for (int i = 0; i < 100 && !(in_frame && pos == FL - 1); i++) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h5A);
        check("pp_count", 32'(count_out),   32'd1);
        check("pp_start", 32'(uart_tx_out), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 8'h00);

        // Random traffic at several offered loads, always honouring ready.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1500; i++) begin
                v = ready_out && ($urandom_range(0, 99) < pct[p]);
                step(1'b0, v, 8'($urandom));
            end
            for (int i = 0; i < 1400; i++) step(1'b0, 1'b0, 8'h00);
            check("rand_drained", 32'(busy_out), 32'd0);
        end

        // Reset during data bit 3 with four bytes still queued.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 200 && !(in_frame && pos == 4 * C + 3); i++) step(1'b0, 1'b0, 8'h00);
        check("mid_queued", 32'(count_out), 32'd4);
        step(1'b1, 1'b0, 8'h00);
        check("mid_rst_line",  32'(uart_tx_out), 32'd1);
        check("mid_rst_count", 32'(count_out),   32'd0);
        check("mid_rst_busy",  32'(busy_out),    32'd0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (!uart_tx_out) lows++;
        end
        check("mid_no_frames", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
